// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M MUL/DIV/REM unit; in clk,rst,start,funct3,SrcA,SrcB,flush; out stall,busy,done,result
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, ADJUST, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3;
  logic neg, negr, spec;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] p;
  logic a_sgn, b_sgn, sa, sb, ovf, is_spec, last;
  logic [XLEN-1:0] a_in, b_in, spec_res, ra, res;
  logic [XLEN:0] mul_sum, rsh, diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, pa;
  assign a_sgn = funct3 == 3'b001 || funct3 == 3'b010 || (funct3[2] && !funct3[0]);
  assign b_sgn = funct3 == 3'b001 || (funct3[2] && !funct3[0]);
  assign sa = a_sgn & SrcA[XLEN-1];
  assign sb = b_sgn & SrcB[XLEN-1];
  assign a_in = sa ? -SrcA : SrcA;
  assign b_in = sb ? -SrcB : SrcB;
  assign ovf = !funct3[0] && SrcA == MIN && SrcB == '1;
  assign is_spec = funct3[2] && (SrcB == '0 || ovf);
  assign spec_res = SrcB == '0 ? (funct3[1] ? SrcA : '1) : (funct3[1] ? '0 : MIN);
  assign last = cnt == CNT_W'(XLEN-1);
  assign mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, a_mag} : '0);
  assign mul_nx = {mul_sum, p[XLEN-1:1]};
  // restoring step: partial remainder shifted left with the next dividend bit
  assign rsh = p[2*XLEN-1:XLEN-1];
  assign diff = rsh - {1'b0, b_mag};
  assign div_nx = diff[XLEN] ? {rsh[XLEN-1:0], p[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
  // the low word of the negated product is also the negated quotient
  assign pa = neg ? -p : p;
  assign ra = negr ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
  assign res = spec ? p[XLEN-1:0] :
               !f3[2] ? (f3[1:0] == 2'b00 ? pa[XLEN-1:0] : pa[2*XLEN-1:XLEN]) :
               f3[1] ? ra : pa[XLEN-1:0];
  assign stall = (state == IDLE && start) || state == CALC || state == ADJUST;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? (is_spec ? ADJUST : CALC) : IDLE;
      CALC:    state_nx = last ? ADJUST : CALC;
      ADJUST:  state_nx = DONE;
      DONE:    state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      f3 <= '0;
      neg <= 1'b0;
      negr <= 1'b0;
      spec <= 1'b0;
      a_mag <= '0;
      b_mag <= '0;
      p <= '0;
      result <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          f3 <= funct3;
          a_mag <= a_in;
          b_mag <= b_in;
          neg <= sa ^ sb;
          negr <= sa;
          spec <= is_spec;
          cnt <= '0;
          p <= {{XLEN{1'b0}}, is_spec ? spec_res : funct3[2] ? a_in : b_in};
        end
        CALC: begin
          p <= f3[2] ? div_nx : mul_nx;
          cnt <= cnt + 1'b1;
        end
        ADJUST: result <= res;
        DONE: ;
      endcase
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic stall, busy, done;
  logic [31:0] result;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  always #5 clk = ~clk;
  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .SrcA(SrcA), .SrcB(SrcB),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] x, y, pr;
    x = (f == 3'd1 || f == 3'd2) ? {{34{a[31]}}, a} : {34'd0, a};
    y = (f == 3'd1) ? {{34{b[31]}}, b} : {34'd0, b};
    pr = x * y;
    if (!f[2]) return f == 3'd0 ? pr[31:0] : pr[63:32];
    if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
    if (!f[0]) return f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return f[1] ? a % b : a / b;
  endfunction
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
  endfunction
  always @(negedge clk)
    if (done) begin
      if (exp_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
      else check(tag_q.pop_front(), result, exp_q.pop_front());
    end
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int k, bad;
    @(negedge clk);
    funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
    exp_q.push_back(model(f, a, b));
    tag_q.push_back(tag);
    #1 check({tag, "_stall_pre"}, 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    SrcA = $urandom; SrcB = $urandom; funct3 = 3'($urandom);
    k = 0; bad = 0;
    while (!done && k < 60) begin
      if (!stall) bad++;
      k++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(k), 32'(lat_of(f, a, b)));
    check({tag, "_stall_busy"}, 32'(bad), 32'd0);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    start = 1'b0;
  endtask
  initial begin
    int k;
    logic [31:0] prev;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD);
    run_op("mulhu_ff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulh_ff", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulhsu_m1_2", 3'd2, 32'hFFFFFFFF, 32'd2);
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom); ra = $urandom; rb = (i == 3) ? 32'd0 : $urandom >> (i * 4);
      run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb);
    end
    prev = result;
    @(negedge clk);
    funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_result_kept", result, prev);
    run_op("after_flush_divu", 3'd5, 32'd1000, 32'd3);
    @(negedge clk);
    funct3 = 3'd0; SrcA = 32'd123; SrcB = 32'd456; start = 1'b1;
    exp_q.push_back(model(3'd0, 32'd123, 32'd456));
    tag_q.push_back("b2b_mul");
    k = 0;
    while (!done && k < 60) begin k++; @(negedge clk); end
    check("b2b_first_latency", 32'(k), 32'd34);
    funct3 = 3'd4; SrcA = 32'hFFFFFF9C; SrcB = 32'd7;
    exp_q.push_back(model(3'd4, 32'hFFFFFF9C, 32'd7));
    tag_q.push_back("b2b_div");
    k = 0;
    @(negedge clk);
    k = 1;
    while (!done && k < 60) begin k++; @(negedge clk); end
    check("b2b_second_gap", 32'(k), 32'd35);
    start = 1'b0;
    @(negedge clk);
    funct3 = 3'd3; SrcA = 32'hDEADBEEF; SrcB = 32'h12345678; start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0; rst = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rstmid_result_after", result, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
